// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state, per-stage widths and field offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } stage_state_e;

  localparam int unsigned IFID_CTRL_W  = 8;
  localparam int unsigned IFID_DATA_W  = 64;
  localparam int unsigned IDEX_CTRL_W  = 8;
  localparam int unsigned IDEX_DATA_W  = 133;
  localparam int unsigned EXMEM_CTRL_W = 8;
  localparam int unsigned EXMEM_DATA_W = 101;
  localparam int unsigned MEMWB_CTRL_W = 8;
  localparam int unsigned MEMWB_DATA_W = 69;

  // EX/MEM control packing
  localparam int unsigned EXMEM_MEMREAD_BIT  = 0;
  localparam int unsigned EXMEM_MEMWRITE_BIT = 1;
  localparam int unsigned EXMEM_REGWRITE_BIT = 2;
  localparam int unsigned EXMEM_BYTESEL_LSB  = 3;
  localparam int unsigned EXMEM_BYTESEL_W    = 2;
  localparam int unsigned EXMEM_MEMTOREG_BIT = 5;

  // EX/MEM data packing: {ALUResult, WriteData, PC, RegDest}
  localparam int unsigned EXMEM_REGDEST_LSB = 0;
  localparam int unsigned EXMEM_PC_LSB      = 5;
  localparam int unsigned EXMEM_WDATA_LSB   = 37;
  localparam int unsigned EXMEM_ALURES_LSB  = 69;

  localparam logic [EXMEM_CTRL_W-1:0] CTRL_BUBBLE_DEFAULT = '0;

endpackage

// File: rtl/pipe_stage_reg_perf_cnt.sv
// Saturating 32-bit event counter (module pipe_perf_cnt), synchronous active-high clear.
module pipe_perf_cnt (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Inc,
  output logic [31:0] Count
);

  logic [31:0] count_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else if (Inc && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with 2-entry skid buffer and synchronous flush.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W      = 8,
  parameter int unsigned       DATA_W      = 101,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] Ctrl_In,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Ctrl_Out,
  output logic [DATA_W-1:0] Data_Out
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       Stall_Count,
  output logic [31:0]       Flush_Count
`endif
);

  stage_state_e      state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              push, pop;

  assign Out_Valid = (state_q != StEmpty);
  assign In_Ready  = in_ready_q;
  assign push      = In_Valid & in_ready_q;
  assign pop       = Out_Valid & Out_Ready;
  assign Ctrl_Out  = Out_Valid ? main_ctrl_q : CTRL_BUBBLE;
  assign Data_Out  = main_data_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d     = StOne;
          main_ctrl_d = Ctrl_In;
          main_data_d = Data_In;
        end
      end
      StOne: begin
        if (push && pop) begin
          main_ctrl_d = Ctrl_In;
          main_data_d = Data_In;
        end else if (pop) begin
          state_d = StEmpty;
        end else if (push) begin
          state_d     = StFull;
          skid_ctrl_d = Ctrl_In;
          skid_data_d = Data_In;
        end
      end
      StFull: begin
        if (pop) begin
          state_d     = StOne;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops everything but leaves the payload registers (and so Data_Out) untouched.
    if (Flush) begin
      state_d     = StEmpty;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
    end
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StEmpty;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .Inc   (Out_Valid & ~Out_Ready),
    .Count (Stall_Count)
  );

  pipe_perf_cnt u_flush_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .Inc   (Flush & (Out_Valid | In_Valid)),
    .Count (Flush_Count)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed plan followed by random traffic vs a queue model.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 101;

  logic          Clock = 1'b0;
  logic          Reset, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready;
  logic [CW-1:0] Ctrl_In, Ctrl_Out;
  logic [DW-1:0] Data_In, Data_Out;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   Stall_Count, Flush_Count;
`endif

  always #5 Clock = ~Clock;

  pipe_stage_reg #(
    .CTRL_W      (CW),
    .DATA_W      (DW),
    .CTRL_BUBBLE ({CW{1'b0}})
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Ctrl_In   (Ctrl_In),
    .Data_In   (Data_In),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Ctrl_Out  (Ctrl_Out),
    .Data_Out  (Data_Out)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .Stall_Count (Stall_Count),
    .Flush_Count (Flush_Count)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // Reference model: the words currently held by the stage, oldest first.
  logic [CW+DW-1:0] q[$];
  logic [DW-1:0]    hold = '0;
  longint unsigned  stall_m = 0;
  longint unsigned  flush_m = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle (called at negedge), check pre-edge outputs, then advance the model.
  task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, input logic rst);
    logic valid, ready;
    In_Valid  = iv;
    Ctrl_In   = c;
    Data_In   = d;
    Out_Ready = ordy;
    Flush     = fl;
    Reset     = rst;
    #1;
    valid = (q.size() != 0);
    ready = (q.size() < 2);
    if (checking) begin
      chk("out_valid", {127'd0, Out_Valid}, {127'd0, valid});
      chk("in_ready", {127'd0, In_Ready}, {127'd0, ready});
      if (valid) chk("ctrl_out", {120'd0, Ctrl_Out}, {120'd0, q[0][DW +: CW]});
      else       chk("ctrl_bubble", {120'd0, Ctrl_Out}, 128'd0);
      chk("data_out", {27'd0, Data_Out}, {27'd0, hold});
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", {96'd0, Stall_Count}, 128'(stall_m > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : stall_m));
      chk("flush_cnt", {96'd0, Flush_Count}, 128'(flush_m > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : flush_m));
`endif
    end
    @(posedge Clock);
    if (rst) begin
      q.delete();
      hold    = '0;
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (valid && !ordy) stall_m++;
      if (fl && (valid || iv)) flush_m++;
      if (fl) begin
        q.delete();
      end else begin
        if (valid && ordy) void'(q.pop_front());
        if (iv && ready) q.push_back({c, d});
      end
      if (q.size() != 0) hold = q[0][DW-1:0];
    end
    @(negedge Clock);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    Ctrl_In = '0; Data_In = '0;
    @(negedge Clock);

    // Reset held two cycles with In_Valid high
    step(1'b1, 8'h11, 101'd1, 1'b1, 1'b0, 1'b1);
    checking = 1'b1;
    step(1'b1, 8'h11, 101'd1, 1'b1, 1'b0, 1'b1);

    // Streaming at full rate
    for (int i = 1; i <= 10; i++) step(1'b1, 8'hA5, DW'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: 1 output, stalled; 2 into skid; 3 waits upstream
    step(1'b1, 8'hA5, 101'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 101'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 101'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 101'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 101'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 101'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with a same-cycle push
    step(1'b1, 8'hC3, 101'd7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 101'd8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 101'd9, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);

    // Reset and Flush together while ONE
    step(1'b1, 8'h5A, 101'd20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 101'd21, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);

    // Stall for five cycles
    step(1'b1, 8'h3C, 101'd30, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), rnd_data(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 63) == 0));
    end
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
